// File: rtl/cnn_conv_layer_p.sv
// Parametrised KxK convolution layer: filter load, line-buffered raster streaming, 2-stage MAC pipeline.
// Define CNN_RELU_EN to clamp negative sums to zero at the output stage.
module cnn_conv_layer_p #(
   parameter int DW  = 4,
   parameter int FW  = 4,
   parameter int K   = 3,
   parameter int IMG = 8,
   localparam int OW = DW + FW + 1 + $clog2(K * K)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   input  logic          i_reuse_flt,
   input  logic          i_flt_valid,
   input  logic [FW-1:0] i_flt_data,
   input  logic          i_pix_valid,
   input  logic [DW-1:0] i_pix_data,
   output logic          o_pix_ready,
   output logic          o_out_valid,
   output logic [OW-1:0] o_out_data,
   output logic          o_out_last,
   output logic          o_busy,
   output logic          o_done
);

   localparam int NC  = K * K;
   localparam int PW  = DW + FW + 1;
   localparam int CW  = $clog2(IMG);
   localparam int FIW = $clog2(NC);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN} state_t;

   state_t                r_state, w_next;
   logic signed [FW-1:0]  r_coef [NC];
   logic [FIW-1:0]        r_fidx;
   logic [CW-1:0]         r_row, r_col;
   logic [DW-1:0]         r_lb  [K-1][IMG];
   logic [DW-1:0]         r_win [K][K];
   logic [DW-1:0]         w_win [K][K];
   logic signed [PW-1:0]  w_prod [NC];
   logic signed [PW-1:0]  r_prod [NC];
   logic signed [OW-1:0]  w_sum, w_sumAct, r_sum;
   logic                  r_drainCnt;
   logic                  r_v1, r_last1, r_v2, r_last2, r_done;
   logic                  w_accept, w_winValid, w_lastPix;

   assign w_accept   = i_pix_valid && o_pix_ready;
   assign w_winValid = (r_row >= CW'(K-1)) && (r_col >= CW'(K-1));
   assign w_lastPix  = (r_row == CW'(IMG-1)) && (r_col == CW'(IMG-1));

   assign o_out_valid = r_v2;
   assign o_out_last  = r_last2;
   assign o_out_data  = r_sum;
   assign o_done      = r_done;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // A start pulse in any state restarts the frame, so it is decoded ahead of the state case.
   always_comb begin
      w_next      = r_state;
      o_busy      = (r_state != S_IDLE);
      o_pix_ready = (r_state == S_STREAM) && !i_start;
      if (i_start) begin
         w_next = i_reuse_flt ? S_STREAM : S_LOAD;
      end else begin
         case (r_state)
            S_IDLE:   ;
            S_LOAD:   if (i_flt_valid && r_fidx == FIW'(NC-1)) w_next = S_STREAM;
            S_STREAM: if (i_pix_valid && w_lastPix) w_next = S_DRAIN;
            S_DRAIN:  if (r_drainCnt) w_next = S_IDLE;
            default:  w_next = S_IDLE;
         endcase
      end
   end

   // Window shifted left by one column with the new column (line buffer rows + incoming pixel) on the right.
   always_comb begin
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++)
            w_win[r][c] = r_win[r][c];
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K-1; c++)
            w_win[r][c] = r_win[r][c+1];
      for (int r = 0; r < K-1; r++)
         w_win[r][K-1] = r_lb[K-2-r][r_col];
      w_win[K-1][K-1] = i_pix_data;
   end

   always_comb begin
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++)
            w_prod[r*K+c] = PW'(r_coef[r*K+c]) * PW'($signed({1'b0, w_win[r][c]}));
   end

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < NC; i++)
         w_sum = w_sum + OW'(r_prod[i]);
`ifdef CNN_RELU_EN
      w_sumAct = w_sum[OW-1] ? '0 : w_sum;
`else
      w_sumAct = w_sum;
`endif
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_fidx     <= '0;
         r_row      <= '0;
         r_col      <= '0;
         r_drainCnt <= 1'b0;
         r_v1       <= 1'b0;
         r_last1    <= 1'b0;
         r_v2       <= 1'b0;
         r_last2    <= 1'b0;
         r_done     <= 1'b0;
         r_sum      <= '0;
         for (int i = 0; i < NC; i++) begin
            r_coef[i] <= '0;
            r_prod[i] <= '0;
         end
         for (int j = 0; j < K-1; j++)
            for (int c = 0; c < IMG; c++)
               r_lb[j][c] <= '0;
         for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
               r_win[r][c] <= '0;
      end else begin
         r_v1       <= w_accept && w_winValid;
         r_last1    <= w_accept && w_lastPix;
         r_v2       <= r_v1 && !i_start;
         r_last2    <= r_last1 && !i_start;
         r_done     <= (r_state == S_DRAIN) && r_drainCnt && !i_start;
         r_drainCnt <= (r_state == S_DRAIN && !i_start) ? ~r_drainCnt : 1'b0;
         if (r_v1) r_sum <= w_sumAct;
         if (i_start) begin
            r_fidx <= '0;
            r_row  <= '0;
            r_col  <= '0;
         end else begin
            if (r_state == S_LOAD && i_flt_valid) begin
               r_coef[r_fidx] <= $signed(i_flt_data);
               r_fidx         <= (r_fidx == FIW'(NC-1)) ? '0 : r_fidx + 1'b1;
            end
            if (w_accept) begin
               if (r_col == CW'(IMG-1)) begin
                  r_col <= '0;
                  r_row <= r_row + 1'b1;
               end else begin
                  r_col <= r_col + 1'b1;
               end
               for (int j = K-2; j >= 1; j--)
                  r_lb[j][r_col] <= r_lb[j-1][r_col];
               r_lb[0][r_col] <= i_pix_data;
               for (int r = 0; r < K; r++)
                  for (int c = 0; c < K; c++)
                     r_win[r][c] <= w_win[r][c];
               for (int i = 0; i < NC; i++)
                  r_prod[i] <= w_prod[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_cnn_conv_layer_p.sv
// Scoreboard bench for cnn_conv_layer_p: a direct convolution model pushes expected results with
// their due cycle as pixels are accepted; a negedge monitor pops and compares them.
module tb_cnn_conv_layer_p;

   localparam int DW   = 4;
   localparam int FW   = 4;
   localparam int K    = 3;
   localparam int IMG  = 8;
   localparam int OW   = DW + FW + 1 + $clog2(K * K);
   localparam int NOUT = (IMG - K + 1) * (IMG - K + 1);

   typedef struct {
      int data;
      bit last;
      int cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          reuseFlt = 1'b0;
   logic          fltValid = 1'b0;
   logic [FW-1:0] fltData = '0;
   logic          pixValid = 1'b0;
   logic [DW-1:0] pixData = '0;
   logic          pixReady, outValid, outLast, busy, done;
   logic [OW-1:0] outData;

   int   nChecks = 0;
   int   nFails = 0;
   int   cyc = 0;
   int   outCount = 0;
   int   lastOutCyc = -10;
   int   tbCoef [K*K];
   int   img [IMG*IMG];
   exp_t sbQ [$];
   exp_t monE;

   cnn_conv_layer_p #(.DW(DW), .FW(FW), .K(K), .IMG(IMG)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_reuse_flt(reuseFlt),
      .i_flt_valid(fltValid), .i_flt_data(fltData),
      .i_pix_valid(pixValid), .i_pix_data(pixData), .o_pix_ready(pixReady),
      .o_out_valid(outValid), .o_out_data(outData), .o_out_last(outLast),
      .o_busy(busy), .o_done(done)
   );

   always #5 clk = ~clk;

   // Cycle index: the interval after posedge n is cycle n.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      nChecks++;
      if (observed !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   // Reference convolution at window bottom-right (r,c), applied directly to the stored image.
   function automatic int convModel(input int r, input int c);
      int s = 0;
      for (int i = 0; i < K; i++)
         for (int j = 0; j < K; j++)
            s += tbCoef[i*K+j] * img[(r-K+1+i)*IMG + (c-K+1+j)];
`ifdef CNN_RELU_EN
      if (s < 0) s = 0;
`endif
      return s;
   endfunction

   function automatic void fillImage(input int pattern);
      for (int r = 0; r < IMG; r++)
         for (int c = 0; c < IMG; c++)
            case (pattern)
               0:       img[r*IMG+c] = 1;
               1:       img[r*IMG+c] = (r*IMG + c) % (1 << DW);
               default: img[r*IMG+c] = 15;
            endcase
   endfunction

   // Drop expected results that an abort or reset will never let appear.
   function automatic void purgeAfter(input int lastKeep);
      exp_t keep [$];
      foreach (sbQ[i]) if (sbQ[i].cyc <= lastKeep) keep.push_back(sbQ[i]);
      sbQ = keep;
   endfunction

   // Monitor: every out_valid must match the oldest outstanding expectation, including its cycle.
   always @(negedge clk) begin
      if (outValid) begin
         outCount++;
         if (sbQ.size() == 0) begin
            checkOutput("unexpectedOut", 1, 0);
         end else begin
            monE = sbQ.pop_front();
            checkOutput("outData", int'($signed(outData)), monE.data);
            checkOutput("outLast", int'(outLast), int'(monE.last));
            checkOutput("outCycle", cyc, monE.cyc);
         end
         if (outLast) lastOutCyc = cyc;
      end
      if (done) checkOutput("doneAfterLast", cyc, lastOutCyc + 1);
   end

   task automatic pulseStart(input bit reuse);
      start = 1'b1;
      reuseFlt = reuse;
      @(negedge clk);
      purgeAfter(cyc);
      @(posedge clk); #1;
      start = 1'b0;
      reuseFlt = 1'b0;
   endtask

   task automatic loadFilter(input int kind);
      for (int i = 0; i < K*K; i++)
         case (kind)
            0:       tbCoef[i] = 1;
            1:       tbCoef[i] = (i == (K*K)/2) ? 1 : 0;
            default: tbCoef[i] = -8;
         endcase
      pulseStart(1'b0);
      for (int i = 0; i < K*K; i++) begin
         fltValid = 1'b1;
         fltData = FW'(tbCoef[i]);
         @(posedge clk); #1;
      end
      fltValid = 1'b0;
   endtask

   task automatic drivePixel(input int r, input int c, input bit fltNoise);
      exp_t e;
      int   waits = 0;
      pixValid = 1'b1;
      pixData = DW'(img[r*IMG+c]);
      if (fltNoise) begin
         fltValid = 1'b1;
         fltData = FW'($urandom);
      end
      @(negedge clk);
      while (!pixReady && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      if (!pixReady) begin
         checkOutput("pixReadyTimeout", 0, 1);
      end else if (r >= K-1 && c >= K-1) begin
         e.data = convModel(r, c);
         e.last = (r == IMG-1) && (c == IMG-1);
         e.cyc = cyc + 2;
         sbQ.push_back(e);
      end
      @(posedge clk); #1;
      pixValid = 1'b0;
      fltValid = 1'b0;
   endtask

   task automatic waitDone();
      int w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!done && w < 20);
      checkOutput("doneSeen", int'(done), 1);
      @(posedge clk); #1;
   endtask

   // Drive nPix pixels of a frame; a full frame also checks result count and completion.
   task automatic applyStimulus(input int pattern, input bit gaps, input bit fltNoise, input int nPix);
      int base;
      fillImage(pattern);
      base = outCount;
      for (int p = 0; p < nPix; p++) begin
         if (gaps) begin
            while ($urandom_range(1, 0) == 1) begin
               fltValid = fltNoise;
               fltData = FW'($urandom);
               @(posedge clk); #1;
            end
         end
         drivePixel(p / IMG, p % IMG, fltNoise);
      end
      if (nPix == IMG*IMG) begin
         waitDone();
         checkOutput("resultCount", outCount - base, NOUT);
         checkOutput("queueEmpty", sbQ.size(), 0);
         checkOutput("idleAfterDone", int'(busy), 0);
      end
   endtask

   initial begin
      int snap;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rstBusy", int'(busy), 0);
      checkOutput("rstPixReady", int'(pixReady), 0);
      checkOutput("rstOutValid", int'(outValid), 0);
      checkOutput("rstOutLast", int'(outLast), 0);
      checkOutput("rstDone", int'(done), 0);
      checkOutput("rstOutData", int'(outData), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      $display("[TB] all-ones filter, all-ones image");
      loadFilter(0);
      applyStimulus(0, 1'b0, 1'b0, IMG*IMG);

      $display("[TB] centre-tap filter, ramp image");
      loadFilter(1);
      applyStimulus(1, 1'b0, 1'b0, IMG*IMG);

      $display("[TB] all -8 filter, saturated image");
      loadFilter(2);
      applyStimulus(2, 1'b0, 1'b0, IMG*IMG);

      $display("[TB] all-ones with random pixel gaps");
      loadFilter(0);
      applyStimulus(0, 1'b1, 1'b0, IMG*IMG);

      $display("[TB] abort after 30 pixels, then reused filter with filter-strobe noise");
      pulseStart(1'b1);
      applyStimulus(0, 1'b0, 1'b0, 30);
      pulseStart(1'b1);
      snap = outCount;
      repeat (5) @(negedge clk);
      checkOutput("abortSilent", outCount - snap, 0);
      @(posedge clk); #1;
      applyStimulus(0, 1'b1, 1'b1, IMG*IMG);

      $display("[TB] reset mid-stream clears filter");
      pulseStart(1'b1);
      applyStimulus(1, 1'b0, 1'b0, 20);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      purgeAfter(-1);
      for (int i = 0; i < K*K; i++) tbCoef[i] = 0;
      @(negedge clk);
      checkOutput("midRstBusy", int'(busy), 0);
      checkOutput("midRstOutValid", int'(outValid), 0);
      @(posedge clk); #1;
      pulseStart(1'b1);
      applyStimulus(0, 1'b0, 1'b0, IMG*IMG);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/cnn_conv_layer_p.md
Name: cnn_conv_layer_p

Overview:
Parametrised single convolution layer and the next generation of the fixed 4/10-bit layer pair. It takes a KxK signed filter, then streams an IMGxIMG unsigned image in raster order and emits every valid-position convolution result, (IMG-K+1)^2 of them, in raster order. Internally it uses a line buffer of K-1 rows plus a KxK window and a 2-stage multiply/accumulate pipeline. Layers cascade by feeding out_data into the next instance's pix_data, with DW of the next instance equal to OW of this one.

Parameters:
DW, 4, image pixel width (unsigned)
FW, 4, filter coefficient width (signed, two's complement)
K, 3, kernel edge length (K>=2, K<=IMG)
IMG, 8, image edge length (square image)
OW (localparam), DW+FW+1+$clog2(K*K), output width; default 13; no overflow possible

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  1-cycle pulse; begins a new frame
reuse_flt  in  1  sampled with start; 1 = keep stored filter and skip LOAD
flt_valid  in  1  filter word strobe
flt_data  in  FW  signed coefficient, row-major order, index 0 = top-left
pix_valid  in  1  pixel strobe
pix_data  in  DW  unsigned pixel
pix_ready  out  1  high while a pixel is accepted this cycle if pix_valid
out_valid  out  1  result strobe, 1 cycle per result
out_data  out  OW  convolution result (signed, or ReLU'd; see Optional Feature)
out_last  out  1  high with the final result of the frame
busy  out  1  high in any state except IDLE
done  out  1  1-cycle pulse on entering IDLE from DRAIN

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; counters, window, line buffer and pipeline valids cleared; filter registers cleared to 0.
- Reset values of outputs: pix_ready, out_valid, out_last, busy and done are all 0; out_data is 0.
- FSM states: IDLE, LOAD, STREAM, DRAIN.
- IDLE -> LOAD on start with reuse_flt=0. IDLE -> STREAM on start with reuse_flt=1.
- LOAD: each flt_valid writes coef[fidx] and increments fidx. After word K*K-1 the FSM goes to STREAM on the next cycle. pix_valid is ignored in LOAD.
- STREAM: pix_ready=1. A pixel is accepted when pix_valid&pix_ready. Row and column counters advance col 0..IMG-1, then the row increments. Gaps in pix_valid are allowed and stall everything upstream of the pipeline. flt_valid is ignored in STREAM.
- Window valid when the accepted pixel has row>=K-1 and col>=K-1. The window covers rows row-K+1..row and cols col-K+1..col.
- Pipeline, for a window-valid pixel accepted at cycle t:
  - stage 1 (t+1): K*K registered products, pixel zero-extended to signed.
  - stage 2 (t+2): registered sum, out_valid=1.
  - Fixed latency of 2 cycles. The pipeline advances every cycle regardless of later pix_valid gaps.
- out_last=1 with the result whose pixel was (IMG-1, IMG-1).
- After accepting pixel (IMG-1, IMG-1): STREAM -> DRAIN, pix_ready=0. DRAIN lasts 2 cycles, then IDLE with done=1 for 1 cycle. done coincides with the cycle after out_last.
- start in LOAD, STREAM or DRAIN aborts the frame: pipeline valids and counters clear, and no out_valid occurs from the next cycle on. The FSM then branches per reuse_flt as from IDLE. A start in LOAD with reuse_flt=1 uses a partially updated filter; that is legal.
- start in the same cycle as the last filter word: start wins, fidx resets to 0.
- Coefficients persist across frames until overwritten or rst.

Optional Feature:
Macro CNN_RELU_EN.
- Defined: stage 2 applies ReLU. A negative sum gives out_data=0; otherwise out_data is the sum. out_data is non-negative, suitable for feeding an unsigned next layer.
- Undefined: out_data is the raw signed sum. Latency is unchanged either way.

Test Plan:
- Defaults; filter all +1; 64 pixels all 1 -> 36 out_valid, each out_data=9; out_last on the 36th; done 1 cycle later.
- Filter with center=1, others 0; pixel p = (row*8+col)%16 -> result (r,c) equals the pixel at (r+1,c+1); first result 2 cycles after accepting pixel (2,2).
- Filter all -8; pixels all 15 -> with CNN_RELU_EN every result 0; without it every result -1080 (fits in 13 bits).
- Random pix_valid gaps (50% duty) with identical data to the first scenario -> identical result sequence, 36 results, no extra or missing out_valid.
- Abort: start pulse after 30 pixels -> no out_valid from the next cycle. Then reuse_flt=1 and a full frame -> 36 results equal to the uninterrupted run, and flt_valid during STREAM has no effect.
- rst asserted mid-STREAM -> next cycle busy=0, out_valid=0. A start with reuse_flt=1 followed by a frame of all-1 pixels gives all results 0, because the filter was cleared.
